mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the Execute stage and the data bus. It accepts one memory operation at a time, with the effective address already computed by the Execute ALU. It then drives a split address/data bus handshake, aligns and extends load data, and presents a single result to the Memory/Writeback stage. Stores are lane-replicated with byte strobes. Misaligned accesses are trapped when alignment checking is configured in.

## Interface
- No parameters; data width fixed at 32.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: Execute offers an operation.
- `in_ready` out 1: unit can accept; high only in IDLE.
- `in_op` in 3: operation code: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- `in_addr` in 32: effective address (vs + sign-extended imm).
- `in_wdata` in 32: store source (vt).
- `req_valid` out 1: bus request.
- `req_write` out 1: 1 = store.
- `req_size` out 2: 0 byte, 1 half, 2 word.
- `req_addr` out 32: bus address.
- `req_strobe` out 4: byte enables, 0 for loads.
- `req_data` out 32: lane-replicated store data.
- `req_addr_ok` in 1: bus accepted address this cycle.
- `resp_data_ok` in 1: bus completed transfer this cycle.
- `resp_data` in 32: raw load word, valid with `resp_data_ok`.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream consumes result.
- `out_rdata` out 32: extended load value; 0 for stores.
- `out_exc_adel` out 1: load address error.
- `out_exc_ades` out 1: store address error.
- `out_badvaddr` out 32: faulting address; 0 when no exception.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: `in_ready`=1. On `in_valid`, capture op, addr and wdata. Go to REQ, or to DONE with the exception flag set when the address is misaligned (see Configuration).
- REQ: `req_valid`=1 with stable fields until `req_addr_ok`.
  - `req_addr_ok` and `resp_data_ok` in the same cycle: go to DONE.
  - `req_addr_ok` alone: go to WAIT.
  - `resp_data_ok` without `req_addr_ok`: protocol violation, ignored.
- WAIT: `req_valid`=0. On `resp_data_ok`, go to DONE.
- DONE: `out_valid`=1 and outputs held stable until `out_ready`, then go to IDLE. There is no IDLE bypass: the next accept happens in the following cycle.
- Load data is registered on the `resp_data_ok` cycle.
  - Byte: `resp_data >> (8*addr[1:0])`, keep bits [7:0]; LB sign-extends from bit 7, LBU zero-extends.
  - Half: `resp_data >> (16*addr[1])`, keep bits [15:0]; LH sign-extends from bit 15, LHU zero-extends.
  - LW: passes `resp_data` unchanged.
- Store lanes:
  - SB: `req_data` = {4{wdata[7:0]}}, strobe = 4'b0001 << addr[1:0].
  - SH: `req_data` = {2{wdata[15:0]}}, strobe = addr[1] ? 4'b1100 : 4'b0011.
  - SW: `req_data` = wdata, strobe = 4'b1111.
- Loads: `req_write`=0, `req_strobe`=0, `req_data`=0.
- `req_addr`: the captured address (low bits per Configuration).

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`=1.
  - `req_valid`=0, `req_write`=0, `req_size`=0, `req_addr`=0, `req_strobe`=0, `req_data`=0.
  - `out_valid`=0, `out_rdata`=0.
  - Both exception outputs 0, `out_badvaddr`=0.
- Latency from an accept in cycle t:
  - `req_valid` is high from cycle t+1.
  - Minimum `out_valid` is t+2, with same-cycle `req_addr_ok`/`resp_data_ok` in t+1.
  - An exception path reaches `out_valid` at t+1.
- Reset mid-transaction drops `req_valid` and `out_valid` in the next cycle. Outstanding bus responses are the bus's responsibility; a late `resp_data_ok` in IDLE is ignored.
- `out_ready` held low stalls in DONE indefinitely, with `in_ready`=0.

## Configuration
- `MEM_ACCESS_ALIGN_CHECK_EN` defined:
  - Misaligned means LH/LHU with addr[0]=1, SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - A misaligned access generates no bus request. The unit goes straight to DONE with `out_exc_adel` (loads) or `out_exc_ades` (stores) set, `out_badvaddr`=addr and `out_rdata`=0.
- Undefined:
  - No alignment trap; exception outputs are tied to 0.
  - `req_addr` has addr[0] cleared for halfword ops and addr[1:0] cleared for word ops.
  - Lane selection uses the cleared address.

## Test plan
- LB at 0x1000_0003, `resp_data`=0x80_00_00_00, `req_addr_ok` and `resp_data_ok` same cycle -> `req_strobe`=0, `out_rdata`=0xFFFF_FF80, `out_valid` 2 cycles after accept.
- LHU at 0x1000_0002, `req_addr_ok` cycle 1, `resp_data_ok` 3 cycles later with 0xBEEF_1234 -> `out_rdata`=0x0000_BEEF, `req_valid` low during WAIT.
- SB 0x0000_00A5 to 0x2000_0001 -> `req_data`=0xA5A5_A5A5, `req_strobe`=4'b0010, `req_write`=1, `out_rdata`=0.
- With `MEM_ACCESS_ALIGN_CHECK_EN`: SW to 0x2000_0006 -> no `req_valid`, `out_exc_ades`=1, `out_badvaddr`=0x2000_0006, `out_valid` at t+1. Without the macro: `req_addr`=0x2000_0004, strobe 4'b1111.
- `out_ready` held low 5 cycles in DONE, then high -> outputs stable, `in_ready`=0 throughout, IDLE next cycle.
- Reset asserted in WAIT -> next cycle all outputs at reset values. A `resp_data_ok` pulse afterwards -> no `out_valid`.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one op at a time over a split address/data bus handshake.
// Optional misalignment trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        req_valid,
  output logic        req_write,
  output logic [1:0]  req_size,
  output logic [31:0] req_addr,
  output logic [3:0]  req_strobe,
  output logic [31:0] req_data,
  input  logic        req_addr_ok,
  input  logic        resp_data_ok,
  input  logic [31:0] resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_exc_adel,
  output logic        out_exc_ades,
  output logic [31:0] out_badvaddr
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        in_ready_q, in_ready_d;
  logic        req_valid_q, req_valid_d;
  logic        req_write_q, req_write_d;
  logic [1:0]  req_size_q, req_size_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [3:0]  req_strobe_q, req_strobe_d;
  logic [31:0] req_data_q, req_data_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        adel_q, adel_d;
  logic        ades_q, ades_d;
  logic [31:0] badvaddr_q, badvaddr_d;

  logic        in_store, trap;
  logic [1:0]  in_size;
  logic [31:0] lane_addr, st_data, byte_sh, half_sh, load_val;
  logic [3:0]  st_strobe;

  // Decode of the incoming op and the lane layout of a store.
  always_comb begin
    in_store = (in_op >= 3'd5);
    case (in_op)
      3'd0, 3'd3, 3'd5: in_size = 2'd0;
      3'd1, 3'd4, 3'd6: in_size = 2'd1;
      default:          in_size = 2'd2;
    endcase
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    trap      = ((in_size == 2'd1) && in_addr[0]) || ((in_size == 2'd2) && (in_addr[1:0] != 2'b00));
    lane_addr = in_addr;
`else
    trap      = 1'b0;
    lane_addr = (in_size == 2'd2) ? {in_addr[31:2], 2'b00} :
                (in_size == 2'd1) ? {in_addr[31:1], 1'b0}  : in_addr;
`endif
    case (in_size)
      2'd0: begin
        st_data   = {4{in_wdata[7:0]}};
        st_strobe = 4'b0001 << lane_addr[1:0];
      end
      2'd1: begin
        st_data   = {2{in_wdata[15:0]}};
        st_strobe = lane_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data   = in_wdata;
        st_strobe = 4'b1111;
      end
    endcase
  end

  // Load alignment/extension from the captured op and bus address.
  always_comb begin
    byte_sh = resp_data >> {req_addr_q[1:0], 3'b000};
    half_sh = resp_data >> {req_addr_q[1], 4'b0000};
    case (op_q)
      3'd0:    load_val = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'd1:    load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      3'd2:    load_val = resp_data;
      3'd3:    load_val = {24'b0, byte_sh[7:0]};
      3'd4:    load_val = {16'b0, half_sh[15:0]};
      default: load_val = 32'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    in_ready_d   = in_ready_q;
    req_valid_d  = req_valid_q;
    req_write_d  = req_write_q;
    req_size_d   = req_size_q;
    req_addr_d   = req_addr_q;
    req_strobe_d = req_strobe_q;
    req_data_d   = req_data_q;
    out_valid_d  = out_valid_q;
    out_rdata_d  = out_rdata_q;
    adel_d       = adel_q;
    ades_d       = ades_q;
    badvaddr_d   = badvaddr_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d       = in_op;
        in_ready_d = 1'b0;
        if (trap) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_rdata_d = 32'b0;
          adel_d      = !in_store;
          ades_d      = in_store;
          badvaddr_d  = in_addr;
        end else begin
          state_d      = REQ;
          req_valid_d  = 1'b1;
          req_write_d  = in_store;
          req_size_d   = in_size;
          req_addr_d   = lane_addr;
          req_strobe_d = in_store ? st_strobe : 4'b0000;
          req_data_d   = in_store ? st_data : 32'b0;
        end
      end
      // A data completion without address acceptance is a bus error and is dropped.
      REQ: if (req_addr_ok) begin
        req_valid_d = 1'b0;
        if (resp_data_ok) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_rdata_d = load_val;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (resp_data_ok) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        out_rdata_d = load_val;
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_rdata_d = 32'b0;
        adel_d      = 1'b0;
        ades_d      = 1'b0;
        badvaddr_d  = 32'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 3'd0;
      in_ready_q   <= 1'b1;
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_size_q   <= 2'd0;
      req_addr_q   <= 32'b0;
      req_strobe_q <= 4'b0;
      req_data_q   <= 32'b0;
      out_valid_q  <= 1'b0;
      out_rdata_q  <= 32'b0;
      adel_q       <= 1'b0;
      ades_q       <= 1'b0;
      badvaddr_q   <= 32'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      in_ready_q   <= in_ready_d;
      req_valid_q  <= req_valid_d;
      req_write_q  <= req_write_d;
      req_size_q   <= req_size_d;
      req_addr_q   <= req_addr_d;
      req_strobe_q <= req_strobe_d;
      req_data_q   <= req_data_d;
      out_valid_q  <= out_valid_d;
      out_rdata_q  <= out_rdata_d;
      adel_q       <= adel_d;
      ades_q       <= ades_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign req_valid    = req_valid_q;
  assign req_write    = req_write_q;
  assign req_size     = req_size_q;
  assign req_addr     = req_addr_q;
  assign req_strobe   = req_strobe_q;
  assign req_data     = req_data_q;
  assign out_valid    = out_valid_q;
  assign out_rdata    = out_rdata_q;
  assign out_exc_adel = adel_q;
  assign out_exc_ades = ades_q;
  assign out_badvaddr = badvaddr_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random ops, bus responder and result monitor.
module tb_mem_access_unit;
  typedef struct packed {logic w; logic [1:0] sz; logic [31:0] addr; logic [3:0] strb; logic [31:0] data;} req_t;
  typedef struct packed {logic [31:0] rdata; logic adel; logic ades; logic [31:0] bad;} res_t;
  typedef struct packed {int da; int dd; logic [31:0] resp;} bus_t;

  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready;
  logic [2:0] in_op = 0;
  logic [31:0] in_addr = 0, in_wdata = 0;
  logic req_valid, req_write;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_data;
  logic [3:0] req_strobe;
  logic req_addr_ok = 0, resp_data_ok = 0;
  logic [31:0] resp_data = 0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_rdata, out_badvaddr;
  logic out_exc_adel, out_exc_ades;

  int checks = 0, errors = 0;
  req_t req_q[$];
  res_t res_q[$];
  bus_t bus_q[$];
  bit force_wait = 0, late_pulse = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_addr(in_addr), .in_wdata(in_wdata), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_strobe(req_strobe), .req_data(req_data),
    .req_addr_ok(req_addr_ok), .resp_data_ok(resp_data_ok), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_exc_adel(out_exc_adel), .out_exc_ades(out_exc_ades), .out_badvaddr(out_badvaddr));

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endfunction

  function automatic void fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endfunction

  // Reference: byte count, signedness and lane offset straight from the op table.
  task automatic model(input logic [2:0] op, input logic [31:0] a, wd, rsp,
                       output req_t rq, output res_t rs, output bit trap);
    int nb; bit st, sg;
    logic [31:0] ea, mask, v;
    st = (op >= 5);
    nb = (op == 0 || op == 3 || op == 5) ? 1 : (op == 1 || op == 4 || op == 6) ? 2 : 4;
    sg = (op == 0 || op == 1);
    trap = 0;
    ea = a;
    if (a % nb != 0) begin
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
      trap = 1;
`else
      ea = a - (a % nb);
`endif
    end
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
    rq.w    = st;
    rq.sz   = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
    rq.addr = ea;
    rq.strb = st ? 4'(((1 << nb) - 1) << (ea % 4)) : 4'd0;
    rq.data = !st ? 32'd0 : (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
              (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
    v = (rsp >> (8 * (ea % 4))) & mask;
    if (sg && v[8 * nb - 1]) v = v | ~mask;
    rs.rdata = (st || trap) ? 32'd0 : v;
    rs.adel  = trap && !st;
    rs.ades  = trap && st;
    rs.bad   = trap ? a : 32'd0;
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_req"}, {req_valid, req_write, req_size, req_addr, req_strobe, req_data}, 128'd0);
    chk({tag, "_out"}, {in_ready, out_valid, out_rdata, out_exc_adel, out_exc_ades, out_badvaddr},
        {60'd0, 1'b1, 67'd0});
  endtask

  // Bus responder: checks request fields every cycle they are presented.
  initial begin : bus
    int ph, cnt;
    bus_t bt;
    ph = 0; cnt = 0; bt = '0;
    forever begin
      @(negedge clk);
      req_addr_ok = 0;
      resp_data_ok = 0;
      resp_data = $urandom;
      if (ph == 3) begin
        chk("done_latency", {out_valid, req_valid}, 2'b10);
        ph = 0;
      end else if (ph == 2) begin
        chk("wait_no_req", req_valid, 1'b0);
        if (force_wait) begin
          if (late_pulse) begin resp_data_ok = 1; ph = 0; end
        end else if (cnt == 0) begin
          resp_data_ok = 1; resp_data = bt.resp; ph = 3;
        end else cnt--;
      end else begin
        if (ph == 0 && req_valid) begin
          if (bus_q.size() == 0) fail("unexpected_req");
          else begin bt = bus_q.pop_front(); ph = 1; cnt = bt.da; end
        end
        if (ph == 1) begin
          if (req_q.size() == 0) fail("req_q_empty");
          else chk("req_fields", {req_write, req_size, req_addr, req_strobe, req_data}, req_q[0]);
          if (cnt == 0) begin
            req_addr_ok = 1;
            if (req_q.size() != 0) void'(req_q.pop_front());
            if (bt.dd == 0) begin resp_data_ok = 1; resp_data = bt.resp; ph = 3; end
            else begin ph = 2; cnt = bt.dd - 1; end
          end else begin
            cnt--;
            if (!force_wait && $urandom_range(0, 2) == 0) resp_data_ok = 1;
          end
        end else if (!force_wait && $urandom_range(0, 5) == 0) resp_data_ok = 1;
      end
    end
  end

  // Result monitor with random back-pressure; the fifth result is stalled 5 cycles.
  initial begin : mon
    bit seen, popped;
    int stall, npop;
    seen = 0; popped = 0; stall = 0; npop = 0;
    forever begin
      @(negedge clk);
      if (popped) begin
        chk("idle_after_done", {out_valid, in_ready}, 2'b01);
        popped = 0;
      end
      if (out_valid) begin
        chk("done_in_ready", in_ready, 1'b0);
        if (res_q.size() == 0) fail("unexpected_result");
        else chk("result", {out_rdata, out_exc_adel, out_exc_ades, out_badvaddr}, res_q[0]);
        if (!seen) begin seen = 1; stall = (npop == 4) ? 5 : $urandom_range(0, 2); end
        if (stall > 0) begin out_ready = 0; stall--; end
        else begin
          out_ready = 1;
          if (res_q.size() != 0) void'(res_q.pop_front());
          npop++; seen = 0; popped = 1;
        end
      end else out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin : stim
    logic [2:0] op;
    logic [31:0] a, wd, rsp;
    int da, dd, w;
    req_t rq; res_t rs; bit trap;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 0;
    for (int i = 0; i < 160; i++) begin
      case (i)
        0: begin op = 0; a = 32'h1000_0003; wd = 0;                rsp = 32'h8000_0000; da = 0; dd = 0; end
        1: begin op = 4; a = 32'h1000_0002; wd = 0;                rsp = 32'hBEEF_1234; da = 0; dd = 3; end
        2: begin op = 5; a = 32'h2000_0001; wd = 32'h0000_00A5;    rsp = 0;             da = 1; dd = 1; end
        3: begin op = 7; a = 32'h2000_0006; wd = 32'h1234_5678;    rsp = 0;             da = 0; dd = 2; end
        4: begin op = 2; a = 32'h0000_0100; wd = 0;                rsp = 32'hCAFE_F00D; da = 2; dd = 0; end
        default: begin
          op = 3'($urandom); a = $urandom; wd = $urandom; rsp = $urandom;
          da = $urandom_range(0, 3); dd = $urandom_range(0, 4);
        end
      endcase
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 200) begin
        in_valid = 1'($urandom_range(0, 1)); in_op = 3'($urandom); in_addr = $urandom;
        @(negedge clk);
        w++;
      end
      if (w >= 200) fail("in_ready_timeout");
      in_valid = 0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      model(op, a, wd, rsp, rq, rs, trap);
      res_q.push_back(rs);
      if (!trap) begin req_q.push_back(rq); bus_q.push_back('{da, dd, rsp}); end
      in_valid = 1; in_op = op; in_addr = a; in_wdata = wd;
      @(negedge clk);
      in_valid = 0;
      chk("accept_in_ready", in_ready, 1'b0);
      chk("accept_next", {req_valid, out_valid}, trap ? 2'b01 : 2'b10);
    end
    w = 0;
    while ((res_q.size() != 0 || bus_q.size() != 0) && w < 2000) begin @(negedge clk); w++; end
    if (w >= 2000) fail("drain_timeout");
    repeat (3) @(negedge clk);

    // Reset while the unit waits for read data; a late completion must be ignored.
    force_wait = 1;
    req_q.push_back('{1'b0, 2'd2, 32'h3000_0000, 4'd0, 32'd0});
    bus_q.push_back('{0, 1, 32'h0});
    in_valid = 1; in_op = 3'd2; in_addr = 32'h3000_0000;
    @(negedge clk);
    in_valid = 0;
    chk("rst_test_req", req_valid, 1'b1);
    @(negedge clk);
    chk("rst_test_wait", {req_valid, out_valid, in_ready}, 3'b000);
    reset = 1;
    @(negedge clk);
    check_reset_vals("midreset");
    reset = 0;
    late_pulse = 1;
    repeat (4) begin
      @(negedge clk);
      chk("late_resp_ignored", {out_valid, req_valid, in_ready}, 3'b001);
    end
    force_wait = 0;
    late_pulse = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
